// File: rtl/delay_sched_pkg.sv
// Shared types for the delay scheduler: FSM encodings and
// the round-robin pointer width helper.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_scheduler_up_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at MAX instead of wrapping.
module up_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/delay_scheduler.sv
// Round-robin owner of one shared delay counter; sequences
// clear/run and pulses done back to the winning requester.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       count
);

  localparam int PW = ptr_width(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    win;
  logic             cnt_clr;
  logic             cnt_en;

  // First requester after ptr, wrapping, so the last owner goes last.
  function automatic logic [PW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [PW-1:0]    p
  );
    logic [PW-1:0] w;
    logic          hit;
    int            j;
    w   = '0;
    hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(p) + i) % N_REQ;
      if (!hit && r[j]) begin
        hit = 1'b1;
        w   = PW'(j);
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    win      = rr_pick(req, ptr_q);
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_LOAD;
          owner_d  = win;
          grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          target_d = len[int'(win)*WIDTH +: WIDTH];
        end
      end
      ST_LOAD: begin
        cnt_clr = 1'b1;
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = (count != target_q);
          if (count == target_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= PW'(N_REQ - 1);
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
    end
  end

  up_counter #(
    .WIDTH(WIDTH),
    .MAX  ({WIDTH{1'b1}})
  ) u_cnt (
    .clk  (clk),
    .rst  (~rst | cnt_clr),
    .en   (cnt_en),
    .count(count)
  );

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE) ? grant_q : '0;

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler: single, round-robin,
// length extremes, abort, mid-run reset, late len change.
module tb_delay_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic           busy;
  logic [N-1:0]   done;
  logic [W-1:0]   count;

  int n_chk;
  int n_fail;

  delay_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .grant(grant),
    .busy (busy),
    .done (done),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " grant"}, 32'(grant), 32'h0);
    check({tag, " busy"},  32'(busy),  32'h0);
    check({tag, " done"},  32'(done),  32'h0);
    check({tag, " count"}, 32'(count), 32'h0);
  endtask

  int exp_g[5];
  int seen;
  int last_c;
  logic [N-1:0] prev_g;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    req    = '0;
    len    = '0;
    rst    = 1'b0;
    @(negedge clk);
    do_reset();
    check_idle("reset");

    // single request, len 5
    len[0 +: W] = 8'd5;
    req = 4'b0001;
    tick();
    check("single load grant", 32'(grant), 32'h1);
    check("single load busy",  32'(busy),  32'h1);
    tick();
    check("single run0 count", 32'(count), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("single run count %0d", k), 32'(count), 32'(k));
      check($sformatf("single run done %0d", k),  32'(done),  32'h0);
    end
    tick();
    check("single done pulse", 32'(done),  32'h1);
    check("single done grant", 32'(grant), 32'h1);
    check("single done count", 32'(count), 32'h5);
    req = '0;
    tick();
    check_idle("single after");

    // round robin, all lengths 2
    do_reset();
    len = {8'd2, 8'd2, 8'd2, 8'd2};
    exp_g = '{1, 2, 4, 8, 1};
    seen = 0;
    last_c = 0;
    prev_g = '0;
    req = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (grant != '0 && prev_g == '0 && seen < 5) begin
        check($sformatf("rr grant %0d", seen), 32'(grant), 32'(exp_g[seen]));
        if (seen > 0)
          check($sformatf("rr period %0d", seen), 32'(c - last_c), 32'd6);
        last_c = c;
        seen++;
      end
      prev_g = grant;
    end
    check("rr grants seen", 32'(seen), 32'd5);
    req = '0;
    tick(2);
    check_idle("rr after");

    // zero length
    do_reset();
    len = '0;
    req = 4'b0001;
    tick();
    check("zero load busy", 32'(busy), 32'h1);
    tick();
    check("zero run count", 32'(count), 32'h0);
    check("zero run done",  32'(done),  32'h0);
    tick();
    check("zero done pulse", 32'(done), 32'h1);
    req = '0;
    tick();
    check("zero after busy", 32'(busy), 32'h0);

    // maximum length, saturates with no wrap
    do_reset();
    len[0 +: W] = 8'd255;
    req = 4'b0001;
    tick(2);
    check("max run0 count", 32'(count), 32'h0);
    tick(255);
    check("max count 255", 32'(count), 32'd255);
    check("max no early done", 32'(done), 32'h0);
    tick();
    check("max done pulse", 32'(done),  32'h1);
    check("max done count", 32'(count), 32'd255);
    tick();
    check("max idle busy",  32'(busy),  32'h0);
    check("max idle count", 32'(count), 32'h0);
    req = '0;
    tick();

    // abort owner 0 at count 3, then requester 1 gets the counter
    do_reset();
    len = '0;
    len[0 +: W] = 8'd5;
    len[W +: W] = 8'd1;
    req = 4'b0011;
    tick();
    check("abort grant0", 32'(grant), 32'h1);
    tick(4);
    check("abort at count3", 32'(count), 32'h3);
    req = 4'b0010;
    tick();
    check_idle("abort");
    tick();
    check("abort next grant", 32'(grant), 32'h2);
    check("abort next busy",  32'(busy),  32'h1);
    tick(2);
    check("abort next count1", 32'(count), 32'h1);
    tick();
    check("abort next done", 32'(done), 32'h2);
    req = '0;
    tick();

    // reset mid-run while ptr favours requester 1
    req = 4'b0001;
    len[0 +: W] = 8'd0;
    tick(3);
    check("rst prep done0", 32'(done), 32'h1);
    req = '0;
    tick();
    len[W +: W] = 8'd9;
    req = 4'b0010;
    tick();
    check("rst grant1", 32'(grant), 32'h2);
    tick(5);
    check("rst at count4", 32'(count), 32'h4);
    req = 4'b0011;
    rst = 1'b0;
    tick();
    check_idle("midrun reset");
    rst = 1'b1;
    tick();
    check("rst priority grant", 32'(grant), 32'h1);
    req = '0;
    tick();

    // len change during run has no effect
    do_reset();
    len = '0;
    len[0 +: W] = 8'd5;
    req = 4'b0001;
    tick(4);
    check("lenchg count2", 32'(count), 32'h2);
    len[0 +: W] = 8'd9;
    tick(3);
    check("lenchg count5", 32'(count), 32'h5);
    tick();
    check("lenchg done", 32'(done),  32'h1);
    check("lenchg cnt",  32'(count), 32'h5);
    req = '0;
    tick();
    check_idle("lenchg after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
